// File: rtl/hh_pkg.sv
// Shared constants and helpers for the Hodgkin-Huxley neuron datapath.
package hh_pkg;

  localparam int STATE_W   = 8;   // membrane state width
  localparam int DEF_ISI_W = 16;  // default interval counter width
  localparam int DEF_CNT_W = 8;   // default spike count width

  // Increment that sticks at max_val instead of wrapping. Callers pass their
  // value and ceiling zero-extended to 32 bits and cast the result back.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/hh_rate_window.sv
// Fixed-length rate window: counts accepted spikes per WIN_CYCLES-cycle
// window and publishes the total with a one-cycle valid at window close.
module hh_rate_window
  import hh_pkg::*;
#(
  parameter int WIN_CYCLES = 1024,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             accept,
  output logic [CNT_W-1:0] rate_count,
  output logic             rate_valid
);

  localparam int               WIN_W    = $clog2(WIN_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);
  localparam logic [31:0]      ACC_MAX  = 32'({CNT_W{1'b1}});

  logic [WIN_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_rate_count;
  logic             r_rate_valid;

  logic             w_win_last;
  logic [CNT_W-1:0] w_acc_next;

  assign w_win_last = (r_win_cnt == WIN_LAST);
  assign w_acc_next = accept ? CNT_W'(sat_inc(32'(r_acc), ACC_MAX)) : r_acc;

  // Window phase and accumulator; the closing cycle also counts its own spike.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      r_win_cnt    <= '0;
      r_acc        <= '0;
      r_rate_count <= '0;
      r_rate_valid <= 1'b0;
    end else if (clr) begin
      r_win_cnt    <= '0;
      r_acc        <= '0;
      r_rate_count <= '0;
      r_rate_valid <= 1'b0;
    end else if (w_win_last) begin
      r_win_cnt    <= '0;
      r_acc        <= '0;
      r_rate_count <= w_acc_next;
      r_rate_valid <= 1'b1;
    end else begin
      r_win_cnt    <= r_win_cnt + WIN_W'(1);
      r_acc        <= w_acc_next;
      r_rate_valid <= 1'b0;
    end
  end

  assign rate_count = r_rate_count;
  assign rate_valid = r_rate_valid;

endmodule

// File: rtl/hh_spike_analyzer.sv
// Spike analyzer for the Hodgkin-Huxley core: qualifies spike edges with a
// refractory lockout and reports ISI, windowed rate, bursts and peak state.
module hh_spike_analyzer
  import hh_pkg::*;
#(
  parameter int WIN_CYCLES = 1024,
  parameter int ISI_W      = DEF_ISI_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MIN_ISI    = 4,
  parameter int BURST_ISI  = 32,
  parameter int BURST_LEN  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [STATE_W-1:0] state,
  input  logic               spike,
  output logic               spike_pulse,
  output logic               reject_pulse,
  output logic [ISI_W-1:0]   isi_last,
  output logic               isi_valid,
  output logic [STATE_W-1:0] peak_v,
  output logic [CNT_W-1:0]   rate_count,
  output logic               rate_valid,
  output logic               burst
);

  localparam int               RUN_W     = $clog2(BURST_LEN + 1);
  localparam logic [ISI_W-1:0] ISI_MAX   = {ISI_W{1'b1}};
  localparam logic [ISI_W-1:0] LOCK_MIN  = ISI_W'(MIN_ISI);
  localparam logic [ISI_W-1:0] BURST_GAP = ISI_W'(BURST_ISI);
  localparam logic [ISI_W-1:0] BURST_END = ISI_W'(BURST_ISI + 1);
  localparam logic [RUN_W-1:0] RUN_FULL  = RUN_W'(BURST_LEN);

  logic               r_spike_q;
  logic               r_spike_pulse;
  logic               r_reject_pulse;
  logic               r_first_seen;
  logic [ISI_W-1:0]   r_isi_cnt;
  logic [ISI_W-1:0]   r_isi_last;
  logic               r_isi_valid;
  logic [STATE_W-1:0] r_run_max;
  logic [STATE_W-1:0] r_peak_v;
  logic [RUN_W-1:0]   r_run;
  logic               r_burst;

  logic               w_edge;
  logic               w_accept;
  logic               w_reject;
  logic [ISI_W-1:0]   w_isi_inc;
  logic [STATE_W-1:0] w_peak_now;
  logic [RUN_W-1:0]   w_run_next;
  logic               w_gap_close;

  assign w_edge      = spike & ~r_spike_q;
  assign w_accept    = w_edge & (~r_first_seen | (r_isi_cnt >= LOCK_MIN));
  assign w_reject    = w_edge & ~w_accept;
  assign w_isi_inc   = ISI_W'(sat_inc(32'(r_isi_cnt), 32'(ISI_MAX)));
  assign w_peak_now  = (state > r_run_max) ? state : r_run_max;
  assign w_gap_close = ~w_accept & (r_isi_cnt == BURST_END);

  // Run length the current edge would produce: extend on a short gap, else restart at one.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    w_run_next = RUN_W'(1);
    if (r_first_seen && (r_isi_cnt <= BURST_GAP))
      w_run_next = (r_run < RUN_FULL) ? r_run + RUN_W'(1) : RUN_FULL;
  end

  // Edge history and the one-cycle accept/reject/ISI pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spike_q      <= 1'b0;
      r_spike_pulse  <= 1'b0;
      r_reject_pulse <= 1'b0;
      r_isi_valid    <= 1'b0;
    end else if (clr) begin
      r_spike_q      <= 1'b0;
      r_spike_pulse  <= 1'b0;
      r_reject_pulse <= 1'b0;
      r_isi_valid    <= 1'b0;
    end else begin
      r_spike_q      <= spike;
      r_spike_pulse  <= w_accept;
      r_reject_pulse <= w_reject;
      r_isi_valid    <= w_accept & r_first_seen;
    end
  end

  // Interval counter; the first accepted spike only arms it, later ones report it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first_seen <= 1'b0;
      r_isi_cnt    <= '0;
      r_isi_last   <= '0;
    end else if (clr) begin
      r_first_seen <= 1'b0;
      r_isi_cnt    <= '0;
      r_isi_last   <= '0;
    end else if (w_accept) begin
      r_first_seen <= 1'b1;
      r_isi_cnt    <= ISI_W'(1);
      if (r_first_seen)
        r_isi_last <= r_isi_cnt;
    end else begin
      r_isi_cnt    <= w_isi_inc;
    end
  end

  // Running maximum of the membrane state, latched and restarted on each accepted spike.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_max <= '0;
      r_peak_v  <= '0;
    end else if (clr) begin
      r_run_max <= '0;
      r_peak_v  <= '0;
    end else if (w_accept) begin
      r_run_max <= '0;
      r_peak_v  <= w_peak_now;
    end else begin
      r_run_max <= w_peak_now;
    end
  end

  // Burst tracking: grows on short gaps, collapses once the gap exceeds BURST_ISI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run   <= '0;
      r_burst <= 1'b0;
    end else if (clr) begin
      r_run   <= '0;
      r_burst <= 1'b0;
    end else if (w_accept) begin
      r_run   <= w_run_next;
      r_burst <= (w_run_next >= RUN_FULL);
    end else if (w_gap_close) begin
      r_run   <= '0;
      r_burst <= 1'b0;
    end
  end

  hh_rate_window #(
    .WIN_CYCLES (WIN_CYCLES),
    .CNT_W      (CNT_W)
  ) u_rate_window (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .accept     (w_accept),
    .rate_count (rate_count),
    .rate_valid (rate_valid)
  );

  assign spike_pulse  = r_spike_pulse;
  assign reject_pulse = r_reject_pulse;
  assign isi_last     = r_isi_last;
  assign isi_valid    = r_isi_valid;
  assign peak_v       = r_peak_v;
  assign burst        = r_burst;

endmodule

// File: tb/tb_hh_spike_analyzer.sv
// Self-checking bench for hh_spike_analyzer: directed scenarios plus a
// randomized run compared against a timestamp-based reference model.
module tb_hh_spike_analyzer;

  localparam int WIN       = 64;
  localparam int MIN_ISI   = 4;
  localparam int BURST_ISI = 8;
  localparam int BURST_LEN = 3;
  localparam int ISI_SAT   = 65535;
  localparam int CNT_SAT   = 255;

  logic        clk, rst, clr, spike;
  logic [7:0]  state;
  logic        spike_pulse, reject_pulse, isi_valid, rate_valid, burst;
  logic [15:0] isi_last;
  logic [7:0]  peak_v, rate_count;

  int n_checks = 0;
  int n_fail   = 0;

  hh_spike_analyzer #(
    .WIN_CYCLES (WIN),
    .ISI_W      (16),
    .CNT_W      (8),
    .MIN_ISI    (MIN_ISI),
    .BURST_ISI  (BURST_ISI),
    .BURST_LEN  (BURST_LEN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .state        (state),
    .spike        (spike),
    .spike_pulse  (spike_pulse),
    .reject_pulse (reject_pulse),
    .isi_last     (isi_last),
    .isi_valid    (isi_valid),
    .peak_v       (peak_v),
    .rate_count   (rate_count),
    .rate_valid   (rate_valid),
    .burst        (burst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Time is counted in cycles since reset/clr; intervals come from the
  // timestamp of the last accepted spike, the peak from a history of states.
  int m_t, m_ref_t, m_win_acc, m_run;
  bit m_prev_spike, m_seen;
  int m_hist[$];
  bit e_spike_pulse, e_reject_pulse, e_isi_valid, e_rate_valid, e_burst;
  int e_isi_last, e_peak_v, e_rate_count;

  function automatic void model_reset();
    m_t = 0; m_ref_t = 0; m_win_acc = 0; m_run = 0;
    m_prev_spike = 0; m_seen = 0;
    m_hist.delete();
    e_spike_pulse = 0; e_reject_pulse = 0; e_isi_valid = 0; e_rate_valid = 0; e_burst = 0;
    e_isi_last = 0; e_peak_v = 0; e_rate_count = 0;
  endfunction

  function automatic void model_cycle(input bit sp, input int st, input bit cl);
    bit edge_now, acc;
    int elapsed, pk;
    if (cl) begin
      model_reset();
      return;
    end
    edge_now = sp && !m_prev_spike;
    elapsed  = m_t - m_ref_t;
    if (elapsed > ISI_SAT) elapsed = ISI_SAT;
    acc = edge_now && (!m_seen || elapsed >= MIN_ISI);
    m_hist.push_back(st);
    e_spike_pulse  = acc;
    e_reject_pulse = edge_now && !acc;
    e_isi_valid    = acc && m_seen;
    if (acc && m_seen) e_isi_last = elapsed;
    if (acc) begin
      pk = 0;
      foreach (m_hist[i]) if (m_hist[i] > pk) pk = m_hist[i];
      e_peak_v = pk;
      m_hist.delete();
      if (m_seen && elapsed <= BURST_ISI) m_run = (m_run + 1 > BURST_LEN) ? BURST_LEN : m_run + 1;
      else m_run = 1;
      e_burst   = (m_run >= BURST_LEN);
      m_seen    = 1;
      m_ref_t   = m_t;
      m_win_acc = m_win_acc + 1;
    end else if (elapsed == BURST_ISI + 1) begin
      m_run   = 0;
      e_burst = 0;
    end
    if (m_t % WIN == WIN - 1) begin
      e_rate_count = (m_win_acc > CNT_SAT) ? CNT_SAT : m_win_acc;
      e_rate_valid = 1;
      m_win_acc    = 0;
    end else begin
      e_rate_valid = 0;
    end
    m_prev_spike = sp;
    m_t++;
  endfunction

  // Drive one cycle of inputs, advance the model with them, sample 1 ns after the edge.
  task automatic step(input bit sp, input logic [7:0] st, input bit cl);
    spike = sp; state = st; clr = cl;
    @(posedge clk);
    model_cycle(sp, int'(st), cl);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; spike = 1'b0; state = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({spike_pulse, reject_pulse, isi_valid, rate_valid, burst, isi_last, peak_v, rate_count} !== 37'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", {spike_pulse, reject_pulse, isi_valid, rate_valid, burst, isi_last, peak_v, rate_count}); end
    @(negedge clk); rst = 1'b0; model_reset();
    for (int t = 0; t < 15; t++) step(t inside {2, 8, 14}, 8'(t * 3), 1'b0);
    n_checks++; if (burst !== 1'b1) begin n_fail++; $display("FAIL pre_reset_burst: got %0b want 1", burst); end
    n_checks++; if (isi_last !== 16'd6) begin n_fail++; $display("FAIL pre_reset_isi: got %0d want 6", isi_last); end
    // Asynchronous reset in the middle of the window, three spikes already counted.
    rst = 1'b1;
    #1;
    n_checks++; if ({spike_pulse, reject_pulse, isi_valid, rate_valid, burst, isi_last, peak_v, rate_count} !== 37'd0) begin n_fail++; $display("FAIL midrun_reset_outputs: got %h want 0", {spike_pulse, reject_pulse, isi_valid, rate_valid, burst, isi_last, peak_v, rate_count}); end
    model_reset();
    @(negedge clk); rst = 1'b0;
    for (int t = 0; t < WIN; t++) step(t inside {10, 30}, 8'd0, 1'b0);
    n_checks++; if (rate_valid !== 1'b1) begin n_fail++; $display("FAIL post_reset_rate_valid: got %0b want 1", rate_valid); end
    n_checks++; if (rate_count !== 8'd2) begin n_fail++; $display("FAIL post_reset_rate_count: got %0d want 2", rate_count); end
  endtask

  task automatic test_isi();
    step(1'b0, 8'd0, 1'b1);
    for (int t = 0; t <= 40; t++) begin
      step(t inside {10, 11, 30, 31}, 8'd0, 1'b0);
      if (t == 10) begin
        n_checks++; if (spike_pulse !== 1'b1) begin n_fail++; $display("FAIL isi_first_pulse: got %0b want 1", spike_pulse); end
        n_checks++; if (isi_valid !== 1'b0) begin n_fail++; $display("FAIL isi_first_valid: got %0b want 0", isi_valid); end
      end
      if (t == 11) begin
        n_checks++; if (spike_pulse !== 1'b0) begin n_fail++; $display("FAIL isi_level_held: got %0b want 0", spike_pulse); end
      end
      if (t == 30) begin
        n_checks++; if (isi_valid !== 1'b1) begin n_fail++; $display("FAIL isi_second_valid: got %0b want 1", isi_valid); end
        n_checks++; if (isi_last !== 16'd20) begin n_fail++; $display("FAIL isi_value: got %0d want 20", isi_last); end
      end
    end
  endtask

  task automatic test_lockout();
    step(1'b0, 8'd0, 1'b1);
    for (int t = 0; t < 2 * WIN; t++) begin
      step(t inside {100, 102, 104}, 8'd0, 1'b0);
      if (t == 102) begin
        n_checks++; if (reject_pulse !== 1'b1) begin n_fail++; $display("FAIL lock_reject: got %0b want 1", reject_pulse); end
        n_checks++; if (spike_pulse !== 1'b0) begin n_fail++; $display("FAIL lock_no_accept: got %0b want 0", spike_pulse); end
      end
      if (t == 104) begin
        n_checks++; if (spike_pulse !== 1'b1) begin n_fail++; $display("FAIL lock_accept: got %0b want 1", spike_pulse); end
        n_checks++; if (isi_last !== 16'd4) begin n_fail++; $display("FAIL lock_isi: got %0d want 4", isi_last); end
      end
    end
    n_checks++; if (rate_count !== 8'd2) begin n_fail++; $display("FAIL lock_rate_count: got %0d want 2", rate_count); end
  endtask

  task automatic test_window();
    step(1'b0, 8'd0, 1'b1);
    for (int t = 0; t < 2 * WIN; t++) begin
      step(t inside {5, 15, 25, 40, 63}, 8'd0, 1'b0);
      if (t == 63) begin
        n_checks++; if (rate_valid !== 1'b1) begin n_fail++; $display("FAIL win_valid: got %0b want 1", rate_valid); end
        n_checks++; if (rate_count !== 8'd5) begin n_fail++; $display("FAIL win_boundary_count: got %0d want 5", rate_count); end
      end
      if (t == 64) begin
        n_checks++; if (rate_valid !== 1'b0) begin n_fail++; $display("FAIL win_valid_pulse: got %0b want 0", rate_valid); end
      end
    end
    n_checks++; if (rate_count !== 8'd0 || rate_valid !== 1'b1) begin n_fail++; $display("FAIL win_empty: got count %0d valid %0b want 0/1", rate_count, rate_valid); end
  endtask

  task automatic test_burst_peak();
    step(1'b0, 8'd0, 1'b1);
    for (int t = 0; t <= 230; t++) begin
      step(t inside {200, 206, 212, 218}, (t >= 6 && t <= 206) ? 8'(t - 6) : 8'd0, 1'b0);
      if (t == 200) begin
        n_checks++; if (peak_v !== 8'd194) begin n_fail++; $display("FAIL peak_first: got %0d want 194", peak_v); end
      end
      if (t == 206) begin
        n_checks++; if (peak_v !== 8'd200) begin n_fail++; $display("FAIL peak_ramp: got %0d want 200", peak_v); end
      end
      if (t == 211 || t == 227) begin
        n_checks++; if (burst !== 1'b0) begin n_fail++; $display("FAIL burst_low_t%0d: got %0b want 0", t, burst); end
      end
      if (t == 212 || t == 226) begin
        n_checks++; if (burst !== 1'b1) begin n_fail++; $display("FAIL burst_high_t%0d: got %0b want 1", t, burst); end
      end
    end
  endtask

  task automatic test_saturation_clr();
    step(1'b0, 8'd0, 1'b1);
    for (int t = 0; t < 5; t++) step(t == 2, 8'd0, 1'b0);
    repeat (70000) step(1'b0, 8'd0, 1'b0);
    step(1'b1, 8'd0, 1'b0);
    n_checks++; if (isi_valid !== 1'b1) begin n_fail++; $display("FAIL sat_valid: got %0b want 1", isi_valid); end
    n_checks++; if (isi_last !== 16'hFFFF) begin n_fail++; $display("FAIL sat_isi: got %0d want 65535", isi_last); end
    n_checks++; if (isi_last !== 16'(e_isi_last)) begin n_fail++; $display("FAIL sat_isi_model: got %0d want %0d", isi_last, e_isi_last); end
    step(1'b0, 8'd0, 1'b0);
    // clr coincident with an edge wins; the held level then forms a fresh first edge.
    step(1'b1, 8'hFF, 1'b1);
    n_checks++; if ({spike_pulse, reject_pulse, isi_valid, rate_valid, burst, isi_last, peak_v, rate_count} !== 37'd0) begin n_fail++; $display("FAIL clr_outputs: got %h want 0", {spike_pulse, reject_pulse, isi_valid, rate_valid, burst, isi_last, peak_v, rate_count}); end
    step(1'b1, 8'd7, 1'b0);
    n_checks++; if (spike_pulse !== 1'b1) begin n_fail++; $display("FAIL clr_first_pulse: got %0b want 1", spike_pulse); end
    n_checks++; if (isi_valid !== 1'b0) begin n_fail++; $display("FAIL clr_first_no_isi: got %0b want 0", isi_valid); end
    n_checks++; if (peak_v !== 8'd7) begin n_fail++; $display("FAIL clr_peak: got %0d want 7", peak_v); end
  endtask

  task automatic test_random();
    int dens;
    bit sp, cl;
    step(1'b0, 8'd0, 1'b1);
    for (int seg = 0; seg < 20; seg++) begin
      case ($urandom_range(0, 2))
        0:       dens = 2;
        1:       dens = 6;
        default: dens = 25;
      endcase
      for (int c = 0; c < 100; c++) begin
        sp = ($urandom_range(0, dens - 1) == 0);
        cl = ($urandom_range(0, 399) == 0);
        step(sp, 8'($urandom_range(0, 255)), cl);
        n_checks += 8;
        if (spike_pulse !== e_spike_pulse) begin n_fail++; $display("FAIL rnd_spike_pulse t=%0d: got %0b want %0b", m_t, spike_pulse, e_spike_pulse); end
        if (reject_pulse !== e_reject_pulse) begin n_fail++; $display("FAIL rnd_reject_pulse t=%0d: got %0b want %0b", m_t, reject_pulse, e_reject_pulse); end
        if (isi_valid !== e_isi_valid) begin n_fail++; $display("FAIL rnd_isi_valid t=%0d: got %0b want %0b", m_t, isi_valid, e_isi_valid); end
        if (isi_last !== 16'(e_isi_last)) begin n_fail++; $display("FAIL rnd_isi_last t=%0d: got %0d want %0d", m_t, isi_last, e_isi_last); end
        if (peak_v !== 8'(e_peak_v)) begin n_fail++; $display("FAIL rnd_peak_v t=%0d: got %0d want %0d", m_t, peak_v, e_peak_v); end
        if (rate_valid !== e_rate_valid) begin n_fail++; $display("FAIL rnd_rate_valid t=%0d: got %0b want %0b", m_t, rate_valid, e_rate_valid); end
        if (rate_count !== 8'(e_rate_count)) begin n_fail++; $display("FAIL rnd_rate_count t=%0d: got %0d want %0d", m_t, rate_count, e_rate_count); end
        if (burst !== e_burst) begin n_fail++; $display("FAIL rnd_burst t=%0d: got %0b want %0b", m_t, burst, e_burst); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_isi();
    test_lockout();
    test_window();
    test_burst_peak();
    test_saturation_clr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hh_spike_analyzer.md
Name: hh_spike_analyzer

Overview:
- Downstream consumer of the Hodgkin-Huxley neuron core. Takes its 8-bit membrane state and spike line, qualifies spikes with a refractory lockout, and reports:
  - inter-spike interval (ISI)
  - windowed spike rate
  - burst detection
  - peak membrane value per spike
- Outputs drive debug/readout logic feeding the chip's bidirectional pins.

Parameters:
- WIN_CYCLES, 1024: rate window length in clk cycles (>=2).
- ISI_W, 16: ISI counter/output width.
- CNT_W, 8: spike-count width.
- MIN_ISI, 4: refractory lockout. An edge is accepted only if isi_cnt >= MIN_ISI.
- BURST_ISI, 32: maximum ISI, in cycles, that still belongs to a burst.
- BURST_LEN, 3: accepted spikes in a run needed to assert burst.

Ports:
- clk  in  1  system clock, the single clock domain.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear; same effect as reset.
- state  in  8  neuron membrane state, unsigned.
- spike  in  1  neuron spike line, level.
- spike_pulse  out  1  one-cycle pulse per accepted spike.
- reject_pulse  out  1  one-cycle pulse per edge rejected by lockout.
- isi_last  out  ISI_W  last measured ISI in cycles, saturating.
- isi_valid  out  1  one-cycle pulse when isi_last updates.
- peak_v  out  8  max of state since the previous accepted spike.
- rate_count  out  CNT_W  accepted spikes in the last closed window.
- rate_valid  out  1  one-cycle pulse when rate_count updates.
- burst  out  1  level; high while a qualifying burst is in progress.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high. rst, or clr at a clock edge, zeroes every register and output.
- Edge detect: spike_q registers spike. edge = spike & ~spike_q. The cycle in which edge is true is the "edge cycle" t.
- Acceptance: accept = edge & (~first_seen | isi_cnt >= MIN_ISI).
  - An edge that is not accepted produces reject_pulse and changes no other state.
- Latency: all outputs are registered and visible at t+1.
- ISI counter:
  - Reset value 0. On accept, isi_cnt <= 1; otherwise isi_cnt <= isi_cnt+1, saturating at 2^ISI_W-1.
  - For accepted edges at t0 and t1, isi_last = t1-t0. After saturation, isi_last reads 2^ISI_W-1.
- First spike: the first accepted spike after reset/clr sets first_seen and restarts the counter only. It produces no isi_valid and leaves isi_last unchanged.
- Peak tracking:
  - run_max <= max(run_max, state) every cycle.
  - On accept: peak_v <= max(run_max, state), then run_max <= 0.
  - peak_v updates on every accepted spike, including the first.
- Window:
  - win_cnt counts 0..WIN_CYCLES-1 and wraps.
  - acc counts accepted spikes, saturating at 2^CNT_W-1.
  - In the cycle where win_cnt == WIN_CYCLES-1: rate_count <= sat(acc + accept), acc <= 0, rate_valid pulses. A spike on the boundary cycle is counted in the closing window.
- Burst:
  - run = count of consecutive accepted spikes whose ISI <= BURST_ISI. A spike after a longer gap, or the first spike, sets run = 1. run saturates at BURST_LEN.
  - burst <= (run_next >= BURST_LEN) on accept.
  - When isi_cnt == BURST_ISI+1 with no accept: burst <= 0 and run <= 0.
- Simultaneous events: accept and window close in the same cycle are both honoured. clr has priority over everything except rst.
- Reset mid-operation: all state is lost immediately, with no partial window report.

Decomposition:
- Shared package hh_pkg holds:
  - the state width constant (8)
  - default ISI_W/CNT_W
  - the saturating-increment function, which the neuron core also uses
- One sub-module, hh_rate_window, contains win_cnt, acc, rate_count and rate_valid. Inputs: accept, clr. Parameters: WIN_CYCLES, CNT_W.

Test Plan:
All scenarios use bench parameters WIN_CYCLES=64, MIN_ISI=4, BURST_ISI=8, BURST_LEN=3.
- Reset: rst=1 mid-window with acc=3 -> all outputs 0 immediately. After release, the next window reports rate_count counting only post-reset spikes.
- ISI: spike high in cycles 10-11 and 30-31 ->
  - spike_pulse at 11 and 31
  - no isi_valid at 11
  - isi_valid at 31 with isi_last=20
- Lockout: accepted edge at 100, edges at 102 and 104 (isi_cnt 2 and 4) ->
  - reject_pulse at 103
  - spike_pulse at 105 with isi_last=4
  - acc incremented twice
- Window: 5 accepted spikes including one edge exactly on cycle 63 -> rate_valid at 64 with rate_count=5, then acc=0. The next window with no spikes reports 0.
- Burst and peak:
  - Edges at 200, 206, 212, 218 -> burst rises at 213 and falls at 228 (isi_cnt=9 at 227).
  - state ramps 0..200 before the 206 edge -> peak_v=200 at 207.
- Saturation/clr: no spikes for 70000 cycles, then an edge -> isi_last=65535. clr pulse then edge -> no isi_valid, because first_seen was cleared.
